// File: rtl/ysyx_23060203_lsu_pkg.sv
// rtl/ysyx_23060203_lsu_pkg.sv - shared constants, FSM states and width decode for the LSU
package ysyx_23060203_lsu_pkg;

    localparam int MEM_W = 32;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_e;

    // Reserved funct3 codes fall into the word case.
    function automatic lsu_size_e lsu_size(input logic [2:0] func);
        case (func)
            LSU_B, LSU_BU: lsu_size = SZ_BYTE;
            LSU_H, LSU_HU: lsu_size = SZ_HALF;
            LSU_W:         lsu_size = SZ_WORD;
            default:       lsu_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060203_lsu_if.sv
// rtl/ysyx_23060203_lsu_if.sv - word-addressed memory bus between the LSU (master) and memory (slave)
interface ysyx_23060203_lsu_if;
    import ysyx_23060203_lsu_pkg::*;

    logic             bus_req_valid;
    logic             bus_req_ready;
    logic             bus_req_wen;
    logic [MEM_W-1:0] bus_req_addr;
    logic [MEM_W-1:0] bus_req_wdata;
    logic [3:0]       bus_req_wstrb;
    logic             bus_resp_valid;
    logic             bus_resp_ready;
    logic [MEM_W-1:0] bus_resp_rdata;
    logic             bus_resp_err;

    modport master (
        output bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb,
        output bus_resp_ready,
        input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
    );

    modport slave (
        input  bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb,
        input  bus_resp_ready,
        output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
    );

endinterface

// File: rtl/ysyx_23060203_lsu_align.sv
// rtl/ysyx_23060203_lsu_align.sv - store lane shift/strobes, load extract/extend, misalign flag
// Misalign detection only when YSYX_23060203_LSU_MISALIGN_CHK_EN is defined.
module ysyx_23060203_lsu_align
    import ysyx_23060203_lsu_pkg::*;
(
    input  logic [2:0]       func_i,
    input  logic [1:0]       addr_lo_i,
    input  logic [MEM_W-1:0] wdata_i,
    input  logic [MEM_W-1:0] rdata_i,
    output logic [3:0]       wstrb_o,
    output logic [MEM_W-1:0] wdata_o,
    output logic [MEM_W-1:0] rdata_o,
    output logic             misalign_o
);

    lsu_size_e   size;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    assign size = lsu_size(func_i);
    assign sext = ~func_i[2];

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size)
            SZ_BYTE: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {24'b0, wdata_i[7:0]} << {addr_lo_i, 3'b000};
                rdata_o = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {16'b0, wdata_i[15:0]} << {addr_lo_i[1], 4'b0000};
                rdata_o = {{16{sext & half_sel[15]}}, half_sel};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

`ifdef YSYX_23060203_LSU_MISALIGN_CHK_EN
    assign misalign_o = ((size == SZ_HALF) && addr_lo_i[0]) ||
                        ((size == SZ_WORD) && (addr_lo_i != 2'b00));
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/ysyx_23060203_lsu.sv
// rtl/ysyx_23060203_lsu.sv - multi-cycle load/store unit: IDLE/REQ/WAIT/DONE over a valid/ready bus
// Optional misaligned-access trap under YSYX_23060203_LSU_MISALIGN_CHK_EN.
module ysyx_23060203_lsu
    import ysyx_23060203_lsu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     in_ren_i,
    input  logic                     in_wen_i,
    input  logic [2:0]               in_func_i,
    input  logic [MEM_W-1:0]         in_addr_i,
    input  logic [MEM_W-1:0]         in_wdata_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [MEM_W-1:0]         out_rdata_o,
    output logic                     out_err_o,
    ysyx_23060203_lsu_if.master      bus
);

    lsu_state_e       state_q;
    logic [2:0]       func_q;
    logic [1:0]       addr_lo_q;
    logic             wen_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [MEM_W-1:0] out_rdata_q;
    logic             out_err_q;
    logic             req_valid_q;
    logic             req_wen_q;
    logic [MEM_W-1:0] req_addr_q;
    logic [MEM_W-1:0] req_wdata_q;
    logic [3:0]       req_wstrb_q;
    logic             resp_ready_q;

    logic [2:0]       sel_func;
    logic [1:0]       sel_addr_lo;
    logic [3:0]       al_wstrb;
    logic [MEM_W-1:0] al_wdata;
    logic [MEM_W-1:0] al_rdata;
    logic             al_misalign;
    logic             mem_op;

    // In IDLE the aligner looks at the incoming request (strobes, misalign);
    // afterwards it looks at the latched op for load extraction.
    assign sel_func    = (state_q == LSU_IDLE) ? in_func_i       : func_q;
    assign sel_addr_lo = (state_q == LSU_IDLE) ? in_addr_i[1:0]  : addr_lo_q;
    assign mem_op      = in_ren_i | in_wen_i;

    ysyx_23060203_lsu_align u_align (
        .func_i     (sel_func),
        .addr_lo_i  (sel_addr_lo),
        .wdata_i    (in_wdata_i),
        .rdata_i    (bus.bus_resp_rdata),
        .wstrb_o    (al_wstrb),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LSU_IDLE;
            func_q       <= 3'b000;
            addr_lo_q    <= 2'b00;
            wen_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_rdata_q  <= '0;
            out_err_q    <= 1'b0;
            req_valid_q  <= 1'b0;
            req_wen_q    <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= 4'b0000;
            resp_ready_q <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (in_valid_i) begin
                        func_q     <= in_func_i;
                        addr_lo_q  <= in_addr_i[1:0];
                        wen_q      <= in_wen_i;
                        in_ready_q <= 1'b0;
                        if (mem_op && !al_misalign) begin
                            req_valid_q <= 1'b1;
                            req_wen_q   <= in_wen_i;
                            req_addr_q  <= {in_addr_i[MEM_W-1:2], 2'b00};
                            req_wstrb_q <= in_wen_i ? al_wstrb : 4'b1111;
                            req_wdata_q <= in_wen_i ? al_wdata : '0;
                            state_q     <= LSU_REQ;
                        end else begin
                            // No-op or trapped misaligned access: bypass the bus.
                            out_valid_q <= 1'b1;
                            out_rdata_q <= '0;
                            out_err_q   <= mem_op & al_misalign;
                            state_q     <= LSU_DONE;
                        end
                    end
                end
                LSU_REQ: begin
                    if (bus.bus_req_ready) begin
                        req_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                        state_q      <= LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    if (bus.bus_resp_valid) begin
                        resp_ready_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                        out_rdata_q  <= wen_q ? '0 : al_rdata;
                        out_err_q    <= bus.bus_resp_err;
                        state_q      <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= LSU_IDLE;
                    end
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_rdata_o = out_rdata_q;
    assign out_err_o   = out_err_q;

    assign bus.bus_req_valid  = req_valid_q;
    assign bus.bus_req_wen    = req_wen_q;
    assign bus.bus_req_addr   = req_addr_q;
    assign bus.bus_req_wdata  = req_wdata_q;
    assign bus.bus_req_wstrb  = req_wstrb_q;
    assign bus.bus_resp_ready = resp_ready_q;

endmodule
